// File: rtl/idma_axil_write_ctrl.sv
// AXI-Lite write backend sequencer: splits one command into per-beat AW and
// write-datapath requests, bounds outstanding AWs and folds the B responses
// into a single completion per command.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   cmd_valid_i/cmd_ready_o        command handshake (cmd_addr_i, cmd_beats_i = beats-1)
//   aw_valid_o/aw_ready_i          AW meta request, aw_addr_o
//   wdp_valid_o/wdp_ready_i        write datapath beat request
//   b_valid_i/b_ready_o            write response, b_resp_i
//   done_valid_o/done_ready_i      command completion, done_err_o
//   busy_o                         command in flight
module idma_axil_write_ctrl #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned StrbWidth      = 8,
  parameter int unsigned LenWidth       = 8,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_beats_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic                 wdp_valid_o,
  input  logic                 wdp_ready_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [1:0]           b_resp_i,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic                 done_err_o,
  output logic                 busy_o
);

  localparam int unsigned OffWidth = $clog2(StrbWidth);
  localparam int unsigned CntWidth = LenWidth + 1;
  localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [CntWidth-1:0]  total_q, aw_cnt_q, w_cnt_q, b_cnt_q;
  logic [CntWidth-1:0]  aw_cnt_d, w_cnt_d, b_cnt_d;
  logic [OutWidth-1:0]  outst_q;
  logic                 err_q;

  logic                 cmd_hs, aw_hs, w_hs, b_hs;
  logic [AddrWidth-1:0] addr_base, beat_addr;
  logic                 unused_resp;

  assign unused_resp = b_resp_i[0];

  // Beat 0 keeps the unaligned start address, later beats walk bus words.
  assign addr_base = (addr_q >> OffWidth) << OffWidth;
  assign beat_addr = (aw_cnt_q == '0) ? addr_q
                   : addr_base + (AddrWidth'(aw_cnt_q) << OffWidth);

  // Output decode from state and registered counters only.
  always_comb begin
    cmd_ready_o  = 1'b0;
    busy_o       = 1'b1;
    aw_valid_o   = 1'b0;
    aw_addr_o    = '0;
    wdp_valid_o  = 1'b0;
    b_ready_o    = 1'b0;
    done_valid_o = 1'b0;
    done_err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      ISSUE: begin
        aw_valid_o  = (aw_cnt_q < total_q) && (outst_q < OutWidth'(MaxOutstanding));
        aw_addr_o   = beat_addr;
        wdp_valid_o = (w_cnt_q < total_q);
        b_ready_o   = (outst_q != '0);
      end
      DRAIN: begin
        b_ready_o = (outst_q != '0);
      end
      DONE: begin
        done_valid_o = 1'b1;
        done_err_o   = err_q;
      end
      default: ;
    endcase
  end

  assign cmd_hs = cmd_valid_i & cmd_ready_o;
  assign aw_hs  = aw_valid_o & aw_ready_i;
  assign w_hs   = wdp_valid_o & wdp_ready_i;
  assign b_hs   = b_valid_i & b_ready_o;

  // Counter values including this cycle's handshakes.
  assign aw_cnt_d = aw_cnt_q + CntWidth'(aw_hs);
  assign w_cnt_d  = w_cnt_q + CntWidth'(w_hs);
  assign b_cnt_d  = b_cnt_q + CntWidth'(b_hs);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs) state_d = ISSUE;
      ISSUE:   if ((aw_cnt_d == total_q) && (w_cnt_d == total_q)) state_d = DRAIN;
      DRAIN:   if (b_cnt_d == total_q) state_d = DONE;
      DONE:    if (done_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, beat counters, outstanding counter and error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      total_q  <= '0;
      aw_cnt_q <= '0;
      w_cnt_q  <= '0;
      b_cnt_q  <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else if (cmd_hs) begin
      addr_q   <= cmd_addr_i;
      total_q  <= CntWidth'(cmd_beats_i) + CntWidth'(1);
      aw_cnt_q <= '0;
      w_cnt_q  <= '0;
      b_cnt_q  <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      aw_cnt_q <= aw_cnt_d;
      w_cnt_q  <= w_cnt_d;
      b_cnt_q  <= b_cnt_d;
      err_q    <= err_q | (b_hs & b_resp_i[1]);
      case ({aw_hs, b_hs})
        2'b10:   outst_q <= outst_q + OutWidth'(1);
        2'b01:   outst_q <= outst_q - OutWidth'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

endmodule

// File: tb/tb_idma_axil_write_ctrl.sv
// Scoreboard bench for idma_axil_write_ctrl: stimulus pushes expected AW
// addresses and completion error flags; a negedge monitor pops and compares
// on every AW and completion handshake and also plays the B responder.
module tb_idma_axil_write_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned MO = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [LW-1:0] cmd_beats_i = '0;
  logic          aw_valid_o;
  logic          aw_ready_i = 1'b1;
  logic [AW-1:0] aw_addr_o;
  logic          wdp_valid_o;
  logic          wdp_ready_i = 1'b1;
  logic          b_valid_i = 1'b0;
  logic          b_ready_o;
  logic [1:0]    b_resp_i = 2'b00;
  logic          done_valid_o;
  logic          done_ready_i = 1'b1;
  logic          done_err_o;
  logic          busy_o;

  idma_axil_write_ctrl #(
    .AddrWidth(AW), .StrbWidth(8), .LenWidth(LW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_beats_i(cmd_beats_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .wdp_valid_o(wdp_valid_o), .wdp_ready_i(wdp_ready_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_err_o(done_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total_chk = 0;
  int bad_chk   = 0;

  logic [AW-1:0] exp_aw_q[$];
  logic          exp_err_q[$];
  logic [1:0]    resp_q[$];

  int aw_hs_cnt = 0;
  int w_hs_cnt  = 0;
  int b_hs_cnt  = 0;
  int done_cnt  = 0;
  int pending   = 0;
  int b_budget  = 1000000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_chk++;
    if (act !== exp) begin
      bad_chk++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total_chk++;
    bad_chk++;
    $display("FAIL %s", name);
  endtask

  // Monitor and B responder; handshakes seen here complete on the next posedge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      pending   = 0;
      b_valid_i = 1'b0;
    end else begin
      b_valid_i = (pending > 0) && (b_budget > 0);
      b_resp_i  = (resp_q.size() > 0) ? resp_q[0] : 2'b00;
      if (aw_valid_o && aw_ready_i) begin
        chk("aw_outstanding_bound", 64'(pending < MO), 64'(1));
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
        else chk("aw_addr", 64'(aw_addr_o), 64'(exp_aw_q.pop_front()));
        aw_hs_cnt++;
        pending++;
      end
      if (wdp_valid_o && wdp_ready_i) w_hs_cnt++;
      if (b_valid_i && b_ready_o) begin
        b_hs_cnt++;
        pending--;
        b_budget--;
        if (resp_q.size() > 0) void'(resp_q.pop_front());
      end
      if (done_valid_o && done_ready_i) begin
        chk("busy_during_done", 64'(busy_o), 64'(1));
        if (exp_err_q.size() == 0) fail_now("done_unexpected");
        else chk("done_err", 64'(done_err_o), 64'(exp_err_q.pop_front()));
        done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] beats);
    bit ok = 0;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_beats_i = beats;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready_o) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    cmd_valid_i = 1'b0;
    if (!ok) fail_now("cmd_accept_timeout");
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt >= target) return;
      tick();
    end
    fail_now("done_timeout");
  endtask

  // Expected addresses for a 0x..0 aligned start walking 8-byte words.
  task automatic push_linear(input logic [AW-1:0] a, input int n);
    for (int k = 0; k < n; k++) exp_aw_q.push_back(a + AW'(k * 8));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},  64'(cmd_ready_o),  64'(1));
    chk({tag, "_aw_valid"},   64'(aw_valid_o),   64'(0));
    chk({tag, "_aw_addr"},    64'(aw_addr_o),    64'(0));
    chk({tag, "_wdp_valid"},  64'(wdp_valid_o),  64'(0));
    chk({tag, "_b_ready"},    64'(b_ready_o),    64'(0));
    chk({tag, "_done_valid"}, 64'(done_valid_o), 64'(0));
    chk({tag, "_done_err"},   64'(done_err_o),   64'(0));
    chk({tag, "_busy"},       64'(busy_o),       64'(0));
  endtask

  int aw0, w0, b0, d0;

  initial begin
    #2;
    check_reset_outputs("rst");
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Single beat, unaligned address.
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    exp_aw_q.push_back(32'h0000_1003);
    resp_q.push_back(2'b00);
    exp_err_q.push_back(1'b0);
    send_cmd(32'h0000_1003, 8'd0);
    wait_done(1);
    chk("t1_busy_after_done", 64'(busy_o), 64'(0));
    chk("t1_cmd_ready_after_done", 64'(cmd_ready_o), 64'(1));
    repeat (3) tick();
    chk("t1_aw_count", 64'(aw_hs_cnt - aw0), 64'(1));
    chk("t1_w_count", 64'(w_hs_cnt - w0), 64'(1));

    // Multi-beat, unaligned start then aligned words.
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    exp_aw_q.push_back(32'h0000_1005);
    exp_aw_q.push_back(32'h0000_1008);
    exp_aw_q.push_back(32'h0000_1010);
    exp_aw_q.push_back(32'h0000_1018);
    exp_err_q.push_back(1'b0);
    send_cmd(32'h0000_1005, 8'd3);
    wait_done(2);
    chk("t2_aw_count", 64'(aw_hs_cnt - aw0), 64'(4));
    chk("t2_w_count", 64'(w_hs_cnt - w0), 64'(4));
    chk("t2_b_count", 64'(b_hs_cnt - b0), 64'(4));

    // Outstanding limit with held, released and same-cycle B.
    aw0 = aw_hs_cnt; b0 = b_hs_cnt;
    b_budget = 0;
    push_linear(32'h0000_2000, 10);
    exp_err_q.push_back(1'b0);
    send_cmd(32'h0000_2000, 8'd9);
    repeat (20) tick();
    chk("t3_aw_at_limit", 64'(aw_hs_cnt - aw0), 64'(4));
    chk("t3_aw_valid_blocked", 64'(aw_valid_o), 64'(0));
    chk("t3_b_ready", 64'(b_ready_o), 64'(1));
    b_budget = 1;
    repeat (10) tick();
    chk("t3_aw_after_one_b", 64'(aw_hs_cnt - aw0), 64'(5));
    chk("t3_aw_valid_blocked2", 64'(aw_valid_o), 64'(0));
    aw_ready_i = 1'b0;
    b_budget = 1;
    repeat (5) tick();
    chk("t3_aw_valid_below_limit", 64'(aw_valid_o), 64'(1));
    aw_ready_i = 1'b1;
    b_budget = 1;
    repeat (10) tick();
    chk("t3_aw_after_same_cycle", 64'(aw_hs_cnt - aw0), 64'(7));
    chk("t3_b_after_same_cycle", 64'(b_hs_cnt - b0), 64'(3));
    chk("t3_aw_valid_blocked3", 64'(aw_valid_o), 64'(0));
    b_budget = 1000000;
    wait_done(3);
    chk("t3_aw_total", 64'(aw_hs_cnt - aw0), 64'(10));

    // Write datapath stalled while AWs and Bs complete.
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    wdp_ready_i = 1'b0;
    push_linear(32'h0000_3000, 4);
    exp_err_q.push_back(1'b0);
    send_cmd(32'h0000_3000, 8'd3);
    repeat (20) tick();
    chk("t4_aw_done", 64'(aw_hs_cnt - aw0), 64'(4));
    chk("t4_b_done", 64'(b_hs_cnt - b0), 64'(4));
    chk("t4_w_stalled", 64'(w_hs_cnt - w0), 64'(0));
    chk("t4_no_done", 64'(done_valid_o), 64'(0));
    chk("t4_busy", 64'(busy_o), 64'(1));
    wdp_ready_i = 1'b1;
    wait_done(4);
    chk("t4_w_count", 64'(w_hs_cnt - w0), 64'(4));

    // Error aggregation: SLVERR, then EXOKAY only, then DECERR.
    push_linear(32'h0000_4000, 3);
    resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b00);
    exp_err_q.push_back(1'b1);
    send_cmd(32'h0000_4000, 8'd2);
    wait_done(5);
    push_linear(32'h0000_4100, 2);
    resp_q.push_back(2'b00); resp_q.push_back(2'b01);
    exp_err_q.push_back(1'b0);
    send_cmd(32'h0000_4100, 8'd1);
    wait_done(6);
    exp_aw_q.push_back(32'h0000_4200);
    resp_q.push_back(2'b11);
    exp_err_q.push_back(1'b1);
    send_cmd(32'h0000_4200, 8'd0);
    wait_done(7);

    // Address wrap at the top of the address space.
    exp_aw_q.push_back(32'hFFFF_FFF8);
    exp_aw_q.push_back(32'h0000_0000);
    exp_err_q.push_back(1'b0);
    send_cmd(32'hFFFF_FFF8, 8'd1);
    wait_done(8);

    // Reset mid-ISSUE abandons the command without completion.
    b_budget = 0;
    push_linear(32'h0000_5000, 10);
    exp_err_q.push_back(1'b0);
    send_cmd(32'h0000_5000, 8'd9);
    repeat (3) tick();
    chk("t6_busy_before_rst", 64'(busy_o), 64'(1));
    d0 = done_cnt;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_aw_q.delete();
    exp_err_q.delete();
    resp_q.delete();
    b_budget = 1000000;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    chk("t6_cmd_ready_after_rst", 64'(cmd_ready_o), 64'(1));
    chk("t6_no_done_after_rst", 64'(done_cnt - d0), 64'(0));
    exp_aw_q.push_back(32'h0000_0060);
    exp_err_q.push_back(1'b0);
    send_cmd(32'h0000_0060, 8'd0);
    wait_done(9);
    repeat (3) tick();
    chk("end_aw_queue_empty", 64'(exp_aw_q.size()), 64'(0));
    chk("end_done_queue_empty", 64'(exp_err_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end

endmodule
